// File: rtl/jtag_dr_chain_pkg.sv
// jtag_dr_chain_pkg: shared JTAG data-register constants, op decode type and width helper
package jtag_dr_chain_pkg;
  localparam int JTAG_DR_NUM_REGS = 4;
  localparam int JTAG_DR_MAX_W = 32;
  typedef enum logic [2:0] {DR_IDLE, DR_TLR, DR_CAPTURE, DR_SHIFT, DR_UPDATE} dr_op_e;
  function automatic int sel_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jtag_dr_chain_if.sv
// jtag_dr_chain_if: TAP-side and test-data-register-side signals of the DR chain
interface jtag_dr_chain_if
  import jtag_dr_chain_pkg::*;
#(
  parameter int NUM_REGS = JTAG_DR_NUM_REGS,
  parameter int MAX_W = JTAG_DR_MAX_W,
  parameter int SEL_W = sel_width(NUM_REGS),
  parameter int LEN_W = $clog2(MAX_W + 1),
  parameter int CNT_W = LEN_W + 1
);
  logic i_tdi;
  logic o_tdo;
  logic i_stateIsTestLogicReset;
  logic i_stateIsCaptureDr;
  logic i_stateIsShiftDr;
  logic i_stateIsUpdateDr;
  logic i_bypass;
  logic [SEL_W-1:0] i_sel;
  logic [LEN_W-1:0] i_len;
  logic [NUM_REGS*MAX_W-1:0] i_captureData;
  logic [NUM_REGS*MAX_W-1:0] o_updateData;
  logic [NUM_REGS-1:0] o_updateStrobe;
  logic [CNT_W-1:0] o_scanCount;
  logic o_lenMismatch;
  modport master (
    output i_tdi, i_stateIsTestLogicReset, i_stateIsCaptureDr, i_stateIsShiftDr, i_stateIsUpdateDr,
    output i_bypass, i_sel, i_len, i_captureData,
    input o_tdo, o_updateData, o_updateStrobe, o_scanCount, o_lenMismatch
  );
  modport slave (
    input i_tdi, i_stateIsTestLogicReset, i_stateIsCaptureDr, i_stateIsShiftDr, i_stateIsUpdateDr,
    input i_bypass, i_sel, i_len, i_captureData,
    output o_tdo, o_updateData, o_updateStrobe, o_scanCount, o_lenMismatch
  );
endinterface

// File: rtl/jtag_dr_chain_update_bank.sv
// jtag_dr_updateBank: shadow update registers and one-cycle commit strobes
module jtag_dr_updateBank #(
  parameter int NUM_REGS = 4,
  parameter int MAX_W = 32,
  parameter int SEL_W = 2,
  parameter int LEN_W = 6
) (
  input  logic i_tclk,
  input  logic i_trst_n,
  input  logic commit,
  input  logic clr,
  input  logic [SEL_W-1:0] sel_q,
  input  logic [MAX_W-1:0] data,
  input  logic [LEN_W-1:0] len_q,
  output logic [NUM_REGS*MAX_W-1:0] update_data,
  output logic [NUM_REGS-1:0] update_strobe
);
  logic [MAX_W-1:0] mask;
  always_comb
    for (int i = 0; i < MAX_W; i++) mask[i] = i < int'(len_q);
  always_ff @(posedge i_tclk or negedge i_trst_n)
    if (!i_trst_n) begin
      update_data <= '0;
      update_strobe <= '0;
    end else if (clr) begin
      update_data <= '0;
      update_strobe <= '0;
    end else begin
      update_strobe <= commit ? NUM_REGS'(1) << sel_q : '0;
      if (commit) update_data[int'(sel_q)*MAX_W +: MAX_W] <= data & mask;
    end
endmodule

// File: rtl/jtag_dr_chain.sv
// jtag_dr_chain: multi-register JTAG DR shift path with bypass, length check and shadow update; JTAG_TDO_NEGEDGE_EN moves TDO to a falling-edge flop
module jtag_dr_chain
  import jtag_dr_chain_pkg::*;
#(
  parameter int NUM_REGS = JTAG_DR_NUM_REGS,
  parameter int MAX_W = JTAG_DR_MAX_W,
  parameter int SEL_W = sel_width(NUM_REGS),
  parameter int LEN_W = $clog2(MAX_W + 1),
  parameter int CNT_W = LEN_W + 1
) (
  input logic i_tclk,
  input logic i_trst_n,
  jtag_dr_chain_if.slave bus
);
  dr_op_e op;
  logic sel_ok, cap_byp, bypass_q, mismatch, commit;
  logic [SEL_W-1:0] sel_idx, sel_q;
  logic [LEN_W-1:0] eff_len, len_q;
  logic [CNT_W-1:0] count;
  logic [MAX_W-1:0] cap_slice, len_mask, tdi_vec, shift_reg;
  always_comb begin
    op = bus.i_stateIsTestLogicReset ? DR_TLR :
         bus.i_stateIsCaptureDr ? DR_CAPTURE :
         bus.i_stateIsShiftDr ? DR_SHIFT :
         bus.i_stateIsUpdateDr ? DR_UPDATE : DR_IDLE;
    sel_ok = int'(bus.i_sel) < NUM_REGS;
    cap_byp = bus.i_bypass || !sel_ok;
    sel_idx = sel_ok ? bus.i_sel : '0;
    eff_len = cap_byp || bus.i_len == '0 ? LEN_W'(1) :
              int'(bus.i_len) > MAX_W ? LEN_W'(MAX_W) : bus.i_len;
    cap_slice = bus.i_captureData[int'(sel_idx)*MAX_W +: MAX_W];
    for (int i = 0; i < MAX_W; i++) len_mask[i] = i < int'(eff_len);
    tdi_vec = MAX_W'(bus.i_tdi) << (len_q - LEN_W'(1));
    commit = op == DR_UPDATE && !bypass_q && count == {1'b0, len_q};
  end
  always_ff @(posedge i_tclk or negedge i_trst_n)
    if (!i_trst_n) begin
      shift_reg <= '0;
      len_q <= '0;
      bypass_q <= 1'b0;
      sel_q <= '0;
      count <= '0;
      mismatch <= 1'b0;
    end else if (op == DR_TLR) begin
      shift_reg <= '0;
      count <= '0;
      mismatch <= 1'b0;
    end else if (op == DR_CAPTURE) begin
      bypass_q <= cap_byp;
      sel_q <= bus.i_sel;
      len_q <= eff_len;
      shift_reg <= cap_byp ? '0 : cap_slice & len_mask;
      count <= '0;
      mismatch <= 1'b0;
    end else if (op == DR_SHIFT) begin
      shift_reg <= (shift_reg >> 1) | tdi_vec;
      count <= &count ? count : count + CNT_W'(1);
    end else if (op == DR_UPDATE && !bypass_q && !commit)
      mismatch <= 1'b1;
  jtag_dr_updateBank #(
    .NUM_REGS(NUM_REGS), .MAX_W(MAX_W), .SEL_W(SEL_W), .LEN_W(LEN_W)
  ) u_bank (
    .i_tclk(i_tclk),
    .i_trst_n(i_trst_n),
    .commit(commit),
    .clr(op == DR_TLR),
    .sel_q(sel_q),
    .data(shift_reg),
    .len_q(len_q),
    .update_data(bus.o_updateData),
    .update_strobe(bus.o_updateStrobe)
  );
  assign bus.o_scanCount = count;
  assign bus.o_lenMismatch = mismatch;
`ifdef JTAG_TDO_NEGEDGE_EN
  logic tdo_q;
  always_ff @(negedge i_tclk or negedge i_trst_n)
    if (!i_trst_n) tdo_q <= 1'b0;
    else tdo_q <= shift_reg[0];
  assign bus.o_tdo = tdo_q;
`else
  assign bus.o_tdo = shift_reg[0];
`endif
endmodule

// File: tb/tb_jtag_dr_chain.sv
// tb_jtag_dr_chain: directed self-checking bench for jtag_dr_chain
module tb_jtag_dr_chain;
  localparam logic [3:0] S_IDLE = 4'b0000, S_TLR = 4'b1000, S_CAP = 4'b0100, S_SH = 4'b0010, S_UPD = 4'b0001;
  logic tclk = 1'b0;
  logic trst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic b;
  logic [63:0] obs, obs2;
  jtag_dr_chain_if #(.NUM_REGS(4), .MAX_W(32)) bus ();
  jtag_dr_chain #(.NUM_REGS(4), .MAX_W(32)) dut (.i_tclk(tclk), .i_trst_n(trst_n), .bus(bus));
  always #5 tclk = ~tclk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [31:0] upd(input int k);
    return bus.o_updateData[k*32 +: 32];
  endfunction
  task automatic cyc(input logic [3:0] st, input logic tdi, output logic tdo_s);
    {bus.i_stateIsTestLogicReset, bus.i_stateIsCaptureDr, bus.i_stateIsShiftDr, bus.i_stateIsUpdateDr} = st;
    bus.i_tdi = tdi;
    @(negedge tclk);
    #1 tdo_s = bus.o_tdo;
    @(posedge tclk);
    #1;
    {bus.i_stateIsTestLogicReset, bus.i_stateIsCaptureDr, bus.i_stateIsShiftDr, bus.i_stateIsUpdateDr} = S_IDLE;
  endtask
  task automatic capture(input logic byp, input logic [1:0] sel, input logic [5:0] len);
    logic t;
    bus.i_bypass = byp;
    bus.i_sel = sel;
    bus.i_len = len;
    cyc(S_CAP, 1'b0, t);
  endtask
  task automatic shift(input logic [63:0] v, input int n, output logic [63:0] o);
    logic t;
    o = '0;
    for (int i = 0; i < n; i++) begin
      cyc(S_SH, i < 64 ? v[i % 64] : 1'b0, t);
      if (i < 64) o[i] = t;
    end
  endtask
  initial begin
    bus.i_tdi = 1'b0;
    bus.i_stateIsTestLogicReset = 1'b0;
    bus.i_stateIsCaptureDr = 1'b0;
    bus.i_stateIsShiftDr = 1'b0;
    bus.i_stateIsUpdateDr = 1'b0;
    bus.i_bypass = 1'b0;
    bus.i_sel = '0;
    bus.i_len = '0;
    bus.i_captureData = {32'hDEADBEEF, 32'h000000A5, 32'hFFFFFFFF, 32'h0000000F};
    #12;
    chk("rst_tdo", bus.o_tdo, 0);
    chk("rst_cnt", bus.o_scanCount, 0);
    chk("rst_data", bus.o_updateData == '0, 1);
    chk("rst_strobe", bus.o_updateStrobe, 0);
    chk("rst_mis", bus.o_lenMismatch, 0);
    @(posedge tclk);
    #1 trst_n = 1'b1;
    capture(0, 2, 8);
    chk("t1_cnt0", bus.o_scanCount, 0);
    shift(64'h3C, 8, obs);
    chk("t1_tdo", obs, 64'hA5);
    chk("t1_cnt", bus.o_scanCount, 8);
    cyc(S_UPD, 0, b);
    chk("t1_strobe", bus.o_updateStrobe, 4'b0100);
    chk("t1_reg2", upd(2), 32'h3C);
    chk("t1_mis", bus.o_lenMismatch, 0);
    cyc(S_IDLE, 0, b);
    chk("t1_strobe_off", bus.o_updateStrobe, 0);
    chk("t1_reg2_hold", upd(2), 32'h3C);
    capture(0, 2, 8);
    shift(64'h55, 7, obs);
    cyc(S_UPD, 0, b);
    chk("t2_strobe", bus.o_updateStrobe, 0);
    chk("t2_reg2", upd(2), 32'h3C);
    chk("t2_mis", bus.o_lenMismatch, 1);
    cyc(S_IDLE, 0, b);
    chk("t2_mis_hold", bus.o_lenMismatch, 1);
    capture(0, 2, 8);
    chk("t2_mis_clr", bus.o_lenMismatch, 0);
    capture(1, 2, 8);
    shift(64'h3, 3, obs);
    chk("t3_tdo", obs, 64'h6);
    chk("t3_cnt", bus.o_scanCount, 3);
    cyc(S_UPD, 0, b);
    chk("t3_strobe", bus.o_updateStrobe, 0);
    chk("t3_reg0", upd(0), 0);
    chk("t3_reg1", upd(1), 0);
    chk("t3_reg2", upd(2), 32'h3C);
    chk("t3_reg3", upd(3), 0);
    chk("t3_mis", bus.o_lenMismatch, 0);
    capture(0, 1, 0);
    shift(64'h1, 1, obs);
    chk("t4_tdo", obs, 1);
    cyc(S_UPD, 0, b);
    chk("t4_strobe", bus.o_updateStrobe, 4'b0010);
    chk("t4_reg1", upd(1), 1);
    chk("t4_mis", bus.o_lenMismatch, 0);
    capture(0, 3, 40);
    bus.i_len = 5;
    bus.i_sel = 0;
    bus.i_bypass = 1;
    shift(64'h12345678, 32, obs);
    chk("t5_tdo", obs, 64'hDEADBEEF);
    chk("t5_cnt", bus.o_scanCount, 32);
    cyc(S_UPD, 0, b);
    chk("t5_strobe", bus.o_updateStrobe, 4'b1000);
    chk("t5_reg3", upd(3), 32'h12345678);
    chk("t5_mis", bus.o_lenMismatch, 0);
    capture(0, 0, 8);
    shift(64'h6, 4, obs);
    for (int i = 0; i < 3; i++) cyc(S_IDLE, 1, b);
    chk("t6_cnt_pause", bus.o_scanCount, 4);
    shift(64'h9, 4, obs2);
    chk("t6_cnt", bus.o_scanCount, 8);
    chk("t6_tdo", {obs2[3:0], obs[3:0]}, 64'h0F);
    cyc(S_UPD, 0, b);
    chk("t6_strobe", bus.o_updateStrobe, 4'b0001);
    chk("t6_reg0", upd(0), 32'h96);
    capture(0, 0, 8);
    shift(64'h0, 130, obs);
    chk("t7_sat", bus.o_scanCount, 127);
    cyc(S_UPD, 0, b);
    chk("t7_mis", bus.o_lenMismatch, 1);
    chk("t7_reg0", upd(0), 32'h96);
    capture(0, 2, 8);
    shift(64'h7, 3, obs);
    bus.i_stateIsShiftDr = 1'b1;
    @(posedge tclk);
    #2 trst_n = 1'b0;
    #1;
    chk("t8_arst_cnt", bus.o_scanCount, 0);
    chk("t8_arst_data", bus.o_updateData == '0, 1);
    chk("t8_arst_strobe", bus.o_updateStrobe, 0);
    chk("t8_arst_tdo", bus.o_tdo, 0);
    bus.i_stateIsShiftDr = 1'b0;
    @(posedge tclk);
    #1 trst_n = 1'b1;
    capture(0, 1, 4);
    shift(64'hA, 4, obs);
    chk("t8_tdo", obs, 64'hF);
    cyc(S_UPD, 0, b);
    chk("t8_strobe", bus.o_updateStrobe, 4'b0010);
    chk("t8_reg1", upd(1), 32'hA);
    capture(0, 1, 4);
    shift(64'h1, 1, obs);
    cyc(S_UPD, 0, b);
    chk("t8_mis", bus.o_lenMismatch, 1);
    cyc(S_TLR | S_SH | S_UPD, 1, b);
    chk("t8_tlr_data", bus.o_updateData == '0, 1);
    chk("t8_tlr_strobe", bus.o_updateStrobe, 0);
    chk("t8_tlr_cnt", bus.o_scanCount, 0);
    chk("t8_tlr_mis", bus.o_lenMismatch, 0);
    cyc(S_IDLE, 0, b);
    chk("t8_tlr_tdo", b, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/jtag_dr_chain.md
Name: jtag_dr_chain

Overview:
- Parametrised successor to the single fixed-width JTAG shift register.
- Serves NUM_REGS data registers of run-time-selectable length (1..MAX_W), plus a 1-bit bypass path.
- Counts shifted bits and commits a shadow update register on Update-DR only when the scan length is exact.
- Sits between the TAP state decoder / instruction decoder and the design's test data registers.

Parameters:
NUM_REGS, 4, number of selectable data registers
MAX_W, 32, maximum data register length in bits
SEL_W, $clog2(NUM_REGS) (min 1), width of the register select
LEN_W, $clog2(MAX_W+1), width of the length input
CNT_W, LEN_W+1, width of the shifted-bit counter

Ports:
i_tclk  in  1  TCK; all state changes on rising edge
i_trst_n  in  1  async active-low reset
i_tdi  in  1  serial data in
o_tdo  out  1  serial data out, LSB first
i_stateIsTestLogicReset  in  1  TAP in Test-Logic-Reset
i_stateIsCaptureDr  in  1  TAP in Capture-DR
i_stateIsShiftDr  in  1  TAP in Shift-DR
i_stateIsUpdateDr  in  1  TAP in Update-DR
i_bypass  in  1  current instruction selects BYPASS
i_sel  in  SEL_W  selected data register index
i_len  in  LEN_W  length of the selected register
i_captureData  in  NUM_REGS*MAX_W  parallel capture values, register k at [k*MAX_W +: MAX_W]
o_updateData  out  NUM_REGS*MAX_W  shadow update registers, same packing
o_updateStrobe  out  NUM_REGS  one-cycle pulse per committed register
o_scanCount  out  CNT_W  bits shifted since the last capture
o_lenMismatch  out  1  sticky: last update was aborted on a bad scan length

Behaviour:
- Reset (i_trst_n low, async): clears the following to 0: shiftReg, len_q, bypass_q, sel_q, count, all update registers, o_updateStrobe, o_lenMismatch. o_tdo = 0.
- Capture-DR:
  - Samples i_bypass, i_sel and the effective length into bypass_q, sel_q and len_q.
  - Effective length: 1 if bypass; i_len=0 → 1; i_len>MAX_W → MAX_W; otherwise i_len.
  - Out-of-range i_sel (≥NUM_REGS) is treated as bypass.
  - shiftReg = 0 if bypass, else the selected i_captureData slice with bits ≥len_q forced to 0.
  - count = 0; o_lenMismatch = 0.
- Shift-DR:
  - shiftReg shifts right by one; i_tdi enters bit len_q-1; bits ≥len_q stay 0.
  - count increments and saturates at all-ones.
  - Changes on i_sel, i_len or i_bypass during a scan are ignored.
- o_tdo = shiftReg[0] (combinational from the flop) when the optional feature is absent.
- Other states (Pause, Exit, etc.): shiftReg and count hold.
- Update-DR, not bypass, count == len_q: update register sel_q loads shiftReg[len_q-1:0], zero-extended. o_updateStrobe[sel_q] pulses high for exactly the next cycle, registered together with the data.
- Update-DR, not bypass, count != len_q: no update, no strobe, o_lenMismatch set to 1. It holds until the next Capture-DR or reset.
- Update-DR in bypass: no update, no strobe, o_lenMismatch unaffected.
- Test-Logic-Reset: synchronously clears all update registers, shiftReg, count and o_lenMismatch. Takes priority over all other state inputs.
- Simultaneous state inputs, which are illegal from a correct TAP, resolve by priority: TestLogicReset > CaptureDr > ShiftDr > UpdateDr.
- o_scanCount reflects count directly.
- Reset mid-scan: everything returns to reset values; no partial update and no strobe.

Optional Feature:
- Macro: JTAG_TDO_NEGEDGE_EN.
- Defined: o_tdo comes from a flop clocked on the falling edge of i_tclk, sampling shiftReg[0], async reset to 0. This gives IEEE 1149.1-compliant TDO timing with half a cycle of extra latency.
- Undefined: o_tdo is combinational from shiftReg[0]. No negedge logic exists.

Decomposition:
- The shared jtag package gains constants JTAG_DR_NUM_REGS and JTAG_DR_MAX_W, used as parameter defaults.
- Sub-module jtag_dr_updateBank holds the NUM_REGS shadow registers and the strobe generation. Inputs: commit, sel_q, data, len_q, TLR clear.
- The shift path, counter and length clamp stay in the top module.

Test Plan:
- MAX_W=32, sel=2, len=8, capture=0xA5: capture, shift 8 bits of 0x3C → o_tdo emits 1,0,1,0,0,1,0,1. Update writes 0x3C to reg 2, o_updateStrobe = 4'b0100 for one cycle, o_lenMismatch = 0.
- Same setup, shift 7 then update → reg 2 unchanged, no strobe, o_lenMismatch = 1. Next capture → o_lenMismatch = 0.
- bypass=1: capture, shift TDI pattern 1,1,0 → o_tdo = 0,1,1 (one-cycle delay). Update → no strobe, no update register changes.
- i_len=0 → effective length 1. i_len=40 with MAX_W=32 → 32-bit scan, update after exactly 32 shifts. Toggling i_len mid-scan has no effect.
- Pause mid-scan (4 bits, pause 3 cycles, 4 more bits), len=8 → count = 8, update succeeds with the correct data.
- Async reset asserted mid-shift, then Test-Logic-Reset after a successful update → all outputs 0 and update registers 0. With JTAG_TDO_NEGEDGE_EN, o_tdo changes only on falling edges.
